booth_mul_seq: RTL and testbench



---
 rtl/booth_pkg.sv | 28 ++
 rtl/booth_sel.sv | 38 +++
 rtl/booth_mul_seq.sv | 125 ++++++++++++
 tb/tb_booth_mul_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg
// Shared definitions for the sequential radix-4 Booth multiplier:
//   - state_e      : FSM states of booth_mul_seq (IDLE, CALC, DONE)
//   - DIG_*        : 3-bit Booth digit encodings {b[2i+1], b[2i], b[2i-1]}
//   - BOOTH_DIGITS : number of radix-4 digits retired for a given operand width
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] DIG_ZERO_P = 3'b000;
  localparam logic [2:0] DIG_P1_A   = 3'b001;
  localparam logic [2:0] DIG_P1_B   = 3'b010;
  localparam logic [2:0] DIG_P2     = 3'b011;
  localparam logic [2:0] DIG_M2     = 3'b100;
  localparam logic [2:0] DIG_M1_A   = 3'b101;
  localparam logic [2:0] DIG_M1_B   = 3'b110;
  localparam logic [2:0] DIG_ZERO_N = 3'b111;

  // One extra digit beyond WIDTH/2 absorbs the top multiplier bit in unsigned mode.
  function automatic int BOOTH_DIGITS(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_sel.sv
// booth_sel
// Combinational radix-4 Booth partial-product selector.
// Ports:
//   digit  in  3  Booth digit {m[2i+1], m[2i], m[2i-1]}
//   mcand  in  W  current (already shifted) multiplicand
//   pp     out W  selected partial product; one's complement for negative digits
//   neg    out 1  +1 correction completing the two's complement of pp
module booth_sel #(
  parameter int W = 66
) (
  input  logic [2:0]   digit,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] pp,
  output logic         neg
);
  import booth_pkg::*;

  // Negative digits return the inverted operand; the caller adds neg so the
  // two's-complement carry-in costs no separate adder.
  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (digit)
      DIG_ZERO_P, DIG_ZERO_N: pp = '0;
      DIG_P1_A, DIG_P1_B:     pp = mcand;
      DIG_P2:                 pp = mcand << 1;
      DIG_M2: begin
        pp  = ~(mcand << 1);
        neg = 1'b1;
      end
      DIG_M1_A, DIG_M1_B: begin
        pp  = ~mcand;
        neg = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq
// Iterative radix-4 Booth multiplier retiring one digit per clock.
// Ports:
//   clk, resetn           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready high only in IDLE
//   a, b                  multiplicand / multiplier (WIDTH bits)
//   is_signed             1 = two's-complement operands, sampled at accept
//   cancel                synchronous abort of the in-flight operation
//   out_valid / out_ready product handshake; out_valid high only in DONE
//   result                2*WIDTH-bit product a*b, held until handshake
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  input  logic                 cancel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);
  import booth_pkg::*;

  localparam int AW = 2 * WIDTH + 2;
  localparam int MW = WIDTH + 3;
  localparam int N  = BOOTH_DIGITS(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     mcand_q, mcand_d;
  logic [MW-1:0]     mplier_q, mplier_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [AW-1:0]     pp;
  logic              neg;
  logic              ext;

  assign ext = is_signed & b[WIDTH-1];

  booth_sel #(.W(AW)) u_sel (
    .digit (mplier_q[2:0]),
    .mcand (mcand_q),
    .pp    (pp),
    .neg   (neg)
  );

  // Next-state and datapath. The multiplier carries a zero below its LSB so the
  // first digit sees b[-1]=0, and two extension bits so the last digit covers
  // b[WIDTH-1] correctly in both signed and unsigned mode.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !cancel) begin
          state_d  = CALC;
          mcand_d  = is_signed ? {{(AW-WIDTH){a[WIDTH-1]}}, a}
                               : {{(AW-WIDTH){1'b0}}, a};
          mplier_d = {ext, ext, b, 1'b0};
          acc_d    = '0;
          count_d  = '0;
        end
      end
      CALC: begin
        if (cancel) begin
          state_d  = IDLE;
          result_d = '0;
        end else begin
          acc_d    = acc_q + pp + {{(AW-1){1'b0}}, neg};
          mplier_d = {{2{mplier_q[MW-1]}}, mplier_q[MW-1:2]};
          mcand_d  = {mcand_q[AW-3:0], 2'b00};
          count_d  = count_q + CW'(1);
          if (count_q == LAST) begin
            state_d  = DONE;
            result_d = acc_d[2*WIDTH-1:0];
          end
        end
      end
      DONE: begin
        // A cancel coincident with the handshake still clears the product.
        if (cancel) begin
          state_d  = IDLE;
          result_d = '0;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq
// Bench for booth_mul_seq at WIDTH=32: directed cases with hand-computed
// products, then a randomized phase with random handshakes and cancels.
module tb_booth_mul_seq;

  localparam int WIDTH = 32;
  localparam int N     = WIDTH / 2 + 1;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              is_signed = 1'b0;
  logic              cancel = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2*WIDTH-1:0] result;

  int errors = 0;
  int checks = 0;

  booth_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference product: plain 64-bit arithmetic, wrapping mod 2^64.
  function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
    longint sx, sy;
    if (sgn) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Transaction-level model of the unit: idle until an operand pair is taken,
  // busy for N cycles, then holding the product until it is taken or cancelled.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_e;
  mphase_e     mPhase = M_IDLE;
  int          mLeft = 0;
  logic [63:0] mProd = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mPhase = M_IDLE;
      mLeft  = 0;
    end else begin
      case (mPhase)
        M_IDLE: if (in_valid && !cancel) begin
          mPhase = M_BUSY;
          mLeft  = N;
          mProd  = refProduct(a, b, is_signed);
        end
        M_BUSY: if (cancel) mPhase = M_IDLE;
                else begin
                  mLeft--;
                  if (mLeft == 0) mPhase = M_DONE;
                end
        M_DONE: if (cancel || out_ready) mPhase = M_IDLE;
        default: mPhase = M_IDLE;
      endcase
    end
  end

  // Compare the DUT against the model just after every rising edge.
  always @(posedge clk) begin
    #1;
    if (resetn) begin
      checkOutput("in_ready", in_ready, mPhase == M_IDLE);
      checkOutput("out_valid", out_valid, mPhase == M_DONE);
      if (mPhase == M_DONE) checkOutput("result", result, mProd);
    end
  end

  // Present one operand pair at a negedge and hold it until it is accepted.
  // Returns at the negedge right after the accepting edge.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic sgn);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_ready", in_ready, 1);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    is_signed = sgn;
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
  endtask

  // Count edges from accept until out_valid rises, bounded.
  task automatic waitDone(output int edges, output logic [63:0] res);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    res = result;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic runDirected(input string name, input logic [31:0] x, input logic [31:0] y,
                             input logic sgn, input logic [63:0] expected);
    int edges;
    logic [63:0] res;
    applyStimulus(x, y, sgn);
    waitDone(edges, res);
    checkOutput({name, "_latency"}, edges, N);
    checkOutput(name, res, expected);
    releaseResult();
  endtask

  logic [31:0] corners [5];

  initial begin
    int edges;
    logic [63:0] res;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;

    // Reset: outputs must take their reset values while resetn is low.
    #2 resetn = 1'b0;
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", result, 64'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Hand-computed products.
    runDirected("unsigned_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    runDirected("signed_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    runDirected("signed_m1_x3", 32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);

    // Back-pressure: product held for 5 cycles, no accept while DONE.
    applyStimulus(32'd12345, 32'd678, 1'b0);
    waitDone(edges, res);
    checkOutput("bp_latency", edges, N);
    checkOutput("bp_product", res, 64'd8369910);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_hold_result", result, 64'd8369910);
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 32'd100; b = 32'd200; is_signed = 1'b0;
    @(negedge clk);
    checkOutput("bp_after_hs_ready", in_ready, 1);
    checkOutput("bp_after_hs_valid", out_valid, 0);
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_accepted", in_ready, 0);
    in_valid = 1'b0;
    waitDone(edges, res);
    checkOutput("bp_next_latency", edges, N);
    checkOutput("bp_next_product", res, 64'd20000);
    releaseResult();

    // Cancel in IDLE blocks the accept.
    @(negedge clk);
    in_valid = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    checkOutput("idle_cancel_blocks", in_ready, 1);
    in_valid = 1'b0; cancel = 1'b0;

    // Cancel at count 8: back to IDLE, no product ever offered.
    applyStimulus(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel_idle", in_ready, 1);
    repeat (N + 3) begin
      @(negedge clk);
      checkOutput("cancel_no_valid", out_valid, 0);
    end
    runDirected("after_cancel_7x6", 32'd7, 32'd6, 1'b0, 64'd42);

    // Asynchronous reset mid-calculation.
    applyStimulus(32'd1234, 32'd5678, 1'b0);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput("midreset_in_ready", in_ready, 1);
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_result", result, 64'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    runDirected("signed_3xm5", 32'd3, 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);

    // Randomized traffic: the model and compare process check every cycle.
    repeat (4000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = $urandom;
      b         = $urandom;
      if ($urandom_range(0, 4) == 0) a = corners[$urandom_range(0, 4)];
      if ($urandom_range(0, 4) == 0) b = corners[$urandom_range(0, 4)];
      is_signed = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      cancel    = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    cancel    = 1'b0;
    out_ready = 1'b1;
    repeat (N + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
